vga_frame_scanout: RTL
======================

// Module: vga_frame_scanout
// PURPOSE
//  Downstream display stage of the vector ASIP. Generates 640x480@60 VGA timing
//  from the system clock and scans the 8-bit grayscale image that the processor
//  writes into the shared frame memory. It drives rgb/h_sync/v_sync/vga_clk to
//  the board DAC and shows the image only once the processor flags it ready.
// PARAMETERS
//  H_ACTIVE 640 visible pixels per line;  H_FP 16;  H_SYNC 96;  H_BP 48
//  V_ACTIVE 480 visible lines per frame;  V_FP 10;  V_SYNC 2;   V_BP 33
//  IMG_W    256 image width in pixels, power of two
//  IMG_H    256 image height in lines
//  ADDR_W   16  frame-memory address width, >= log2(IMG_W*IMG_H)
// PORTS
//  clk          in   1        system clock, 50 MHz
//  rst          in   1        asynchronous reset, active-low
//  frame_ready  in   1        level from processor: image in memory is complete
//  mem_data     in   8        grayscale pixel, valid 1 clk after mem_addr
//  mem_addr     out  ADDR_W   frame-memory read address
//  rgb          out  24       {R,G,B} pixel to DAC
//  h_sync       out  1        horizontal sync, active-low
//  v_sync       out  1        vertical sync, active-low
//  vga_clk      out  1        pixel clock = clk/2
//  frame_done   out  1        1-clk pulse after last visible pixel of a frame
// BEHAVIOUR
//  - Reset (rst=0, asynchronous): hcnt=0, vcnt=0, vga_clk=0, rgb=0, h_sync=1,
//    v_sync=1, mem_addr=0, frame_done=0, show_img=0. Reset mid-frame aborts the
//    frame; the first frame after release starts at hcnt=0, vcnt=0.
//  - vga_clk toggles on every clk edge. pix_en = (vga_clk==1): the counters,
//    mem_addr, rgb and the syncs update only on clk edges where pix_en=1, so
//    they change once per pixel period (2 clk).
//  - hcnt counts 0..H_TOTAL-1 (H_TOTAL = sum of H_*) and wraps to 0. On that
//    wrap vcnt increments and wraps to 0 after V_TOTAL-1.
//  - Raw sync: hs_raw=0 while H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC;
//    vs_raw=0 likewise with the V_* values. Both are registered through one
//    extra pixel stage so they stay aligned with rgb.
//  - Frame gating: on the pix_en edge where hcnt==0 && vcnt==0, show_img <=
//    frame_ready. show_img is constant for the whole frame, so frame_ready
//    deasserting mid-frame takes effect only at the next frame.
//  - Pipeline, 1 pixel period latency: at pix_en, mem_addr <= {vcnt[..],
//    hcnt[log2(IMG_W)-1:0]} = vcnt*IMG_W+hcnt, and in_img_d <= (hcnt<IMG_W &&
//    vcnt<IMG_H && show_img). mem_data returns on the following non-pix_en edge.
//    At the next pix_en, rgb <= in_img_d ? {3{mem_data}} : 24'h0.
//  - Outside the image window, or outside the active area, mem_addr holds its
//    last in-window value and rgb=0. rgb is 0 throughout all blanking.
//  - frame_done: high for exactly one clk on the pix_en edge where hcnt wraps
//    from H_TOTAL-1 to 0 with vcnt==V_ACTIVE-1. It pulses every frame,
//    regardless of show_img.
//  - All arithmetic is unsigned. The counters are wide enough for H_TOTAL-1
//    and V_TOTAL-1 (10 bits at the defaults). There is no overflow beyond the
//    wrap points.
// TESTING
//  1 Reset: hold rst=0 for 5 clk, toggling frame_ready -> rgb=0, h_sync=1,
//    v_sync=1, vga_clk=0, mem_addr=0 throughout.
//  2 Timing: after release, measure vga_clk period = 2 clk; h_sync low for 96
//    pixels every 800; v_sync low for 2 lines every 525; frame = 420000 pix_en.
//  3 Image: memory model with data=addr[7:0], frame_ready=1 before frame 0 ->
//    pixel (h=5,v=0) gives rgb=24'h050505; (h=3,v=1) reads addr 259 and gives
//    24'h030303; (h=300,v=10) gives 0; (h=10,v=300) gives 0.
//  4 Gating: frame_ready=0 for frame 0 -> all rgb=0. Raise it mid-frame 0 ->
//    still 0 until frame 1, then the image appears. Drop it mid-frame 1 ->
//    frame 1 completes, frame 2 is black.
//  5 Latency: check that rgb for (h,v) appears exactly one pixel period after
//    mem_addr=v*256+h. Check that the h_sync falling edge coincides with the
//    rgb of pixel 656.
//  6 Async reset mid-frame (vcnt=100): outputs go to reset values without a
//    clk edge; after release, frame_done first pulses 384000 pix_en later
//    (480 lines x 800).

Source files
------------

// File: rtl/vga_frame_scanout.sv
// -----------------------------------------------------------------------------
// vga_frame_scanout
//   Display stage of the vector ASIP. Generates VGA timing (640x480@60 with the
//   default parameters) from the system clock and scans an 8-bit grayscale
//   image out of the shared frame memory. The image is shown only for frames
//   that start while the processor holds frame_ready high.
//
// Ports
//   clk          in   system clock (pixel clock is clk/2)
//   rst          in   asynchronous reset, active-low
//   frame_ready  in   level from processor: image in memory is complete
//   mem_data     in   grayscale pixel, valid one clk after mem_addr
//   mem_addr     out  frame-memory read address (v*IMG_W + h)
//   rgb          out  {R,G,B} pixel to the DAC, gray replicated on all three
//   h_sync       out  horizontal sync, active-low, aligned with rgb
//   v_sync       out  vertical sync, active-low, aligned with rgb
//   vga_clk      out  pixel clock, toggles on every clk edge
//   frame_done   out  one-clk pulse after the last visible pixel of a frame
// -----------------------------------------------------------------------------
module vga_frame_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_ready,
    input  logic [7:0]        mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [23:0]       rgb,
    output logic              h_sync,
    output logic              v_sync,
    output logic              vga_clk,
    output logic              frame_done
);

    localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCNT_W      = $clog2(H_TOTAL);
    localparam int VCNT_W      = $clog2(V_TOTAL);
    localparam int IMG_W_LOG   = $clog2(IMG_W);
    localparam int ADDR_FULL_W = VCNT_W + IMG_W_LOG;

    localparam logic [HCNT_W-1:0] H_ONE        = HCNT_W'(1);
    localparam logic [HCNT_W-1:0] H_LAST       = HCNT_W'(H_TOTAL - 1);
    localparam logic [HCNT_W-1:0] H_ACT        = HCNT_W'(H_ACTIVE);
    localparam logic [HCNT_W-1:0] H_IMG        = HCNT_W'(IMG_W);
    localparam logic [HCNT_W-1:0] H_SYNC_START = HCNT_W'(H_ACTIVE + H_FP);
    localparam logic [HCNT_W-1:0] H_SYNC_END   = HCNT_W'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [VCNT_W-1:0] V_ONE        = VCNT_W'(1);
    localparam logic [VCNT_W-1:0] V_LAST       = VCNT_W'(V_TOTAL - 1);
    localparam logic [VCNT_W-1:0] V_ACT        = VCNT_W'(V_ACTIVE);
    localparam logic [VCNT_W-1:0] V_ACT_LAST   = VCNT_W'(V_ACTIVE - 1);
    localparam logic [VCNT_W-1:0] V_IMG        = VCNT_W'(IMG_H);
    localparam logic [VCNT_W-1:0] V_SYNC_START = VCNT_W'(V_ACTIVE + V_FP);
    localparam logic [VCNT_W-1:0] V_SYNC_END   = VCNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic              vga_clk_q,    vga_clk_d;
    logic [HCNT_W-1:0] hcnt_q,       hcnt_d;
    logic [VCNT_W-1:0] vcnt_q,       vcnt_d;
    logic              show_img_q,   show_img_d;
    logic              in_img_q,     in_img_d;
    logic              hs_pipe_q,    hs_pipe_d;
    logic              vs_pipe_q,    vs_pipe_d;
    logic              h_sync_q,     h_sync_d;
    logic              v_sync_q,     v_sync_d;
    logic [23:0]       rgb_q,        rgb_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic              frame_done_q, frame_done_d;

    logic                   pix_en_s;
    logic                   line_end_s;
    logic                   frame_start_s;
    logic                   in_win_s;
    logic [ADDR_FULL_W-1:0] addr_full_s;

    // Pixel-rate enable and position decodes for the current counter value.
    assign pix_en_s      = vga_clk_q;
    assign line_end_s    = (hcnt_q == H_LAST);
    assign frame_start_s = (hcnt_q == '0) && (vcnt_q == '0);
    assign in_win_s      = (hcnt_q < H_IMG) && (hcnt_q < H_ACT) &&
                           (vcnt_q < V_IMG) && (vcnt_q < V_ACT);
    // IMG_W is a power of two, so the linear address is a plain concatenation.
    assign addr_full_s   = {vcnt_q, hcnt_q[IMG_W_LOG-1:0]};

    // Next-state logic: everything except vga_clk advances once per pixel.
    always_comb begin
        vga_clk_d    = ~vga_clk_q;
        hcnt_d       = hcnt_q;
        vcnt_d       = vcnt_q;
        show_img_d   = show_img_q;
        in_img_d     = in_img_q;
        hs_pipe_d    = hs_pipe_q;
        vs_pipe_d    = vs_pipe_q;
        h_sync_d     = h_sync_q;
        v_sync_d     = v_sync_q;
        rgb_d        = rgb_q;
        mem_addr_d   = mem_addr_q;
        frame_done_d = 1'b0;
        if (pix_en_s) begin
            if (line_end_s) begin
                hcnt_d = '0;
                if (vcnt_q == V_LAST) begin
                    vcnt_d = '0;
                end else begin
                    vcnt_d = vcnt_q + V_ONE;
                end
            end else begin
                hcnt_d = hcnt_q + H_ONE;
                vcnt_d = vcnt_q;
            end
            // frame_ready is sampled once per frame; the new value already
            // governs pixel (0,0) so the whole frame sees one decision.
            if (frame_start_s) begin
                show_img_d = frame_ready;
            end else begin
                show_img_d = show_img_q;
            end
            // Outside the image window the address parks on its last value.
            if (in_win_s) begin
                mem_addr_d = ADDR_W'(addr_full_s);
            end else begin
                mem_addr_d = mem_addr_q;
            end
            in_img_d     = in_win_s && show_img_d;
            // Syncs go through two stages so they line up with rgb, which
            // waits one pixel for the memory read.
            hs_pipe_d    = !((hcnt_q >= H_SYNC_START) && (hcnt_q < H_SYNC_END));
            vs_pipe_d    = !((vcnt_q >= V_SYNC_START) && (vcnt_q < V_SYNC_END));
            h_sync_d     = hs_pipe_q;
            v_sync_d     = vs_pipe_q;
            rgb_d        = in_img_q ? {3{mem_data}} : 24'h00_0000;
            frame_done_d = line_end_s && (vcnt_q == V_ACT_LAST);
        end else begin
            frame_done_d = 1'b0;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vga_clk_q    <= 1'b0;
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            show_img_q   <= 1'b0;
            in_img_q     <= 1'b0;
            hs_pipe_q    <= 1'b1;
            vs_pipe_q    <= 1'b1;
            h_sync_q     <= 1'b1;
            v_sync_q     <= 1'b1;
            rgb_q        <= 24'h00_0000;
            mem_addr_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            vga_clk_q    <= vga_clk_d;
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            show_img_q   <= show_img_d;
            in_img_q     <= in_img_d;
            hs_pipe_q    <= hs_pipe_d;
            vs_pipe_q    <= vs_pipe_d;
            h_sync_q     <= h_sync_d;
            v_sync_q     <= v_sync_d;
            rgb_q        <= rgb_d;
            mem_addr_q   <= mem_addr_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign vga_clk    = vga_clk_q;
    assign mem_addr   = mem_addr_q;
    assign rgb        = rgb_q;
    assign h_sync     = h_sync_q;
    assign v_sync     = v_sync_q;
    assign frame_done = frame_done_q;

endmodule
